// File: rtl/dsp_mac_pkg.sv
// Shared constants for the dsp_mac_pipe MAC slice: MODE bit positions,
// post-adder Z-mux encodings and pipeline depth.
package dsp_mac_pkg;

  localparam int MODE_W          = 5;
  localparam int MODE_PREADD_EN  = 0;
  localparam int MODE_PREADD_SUB = 1;
  localparam int MODE_ZSEL_LO    = 2;
  localparam int MODE_ZSEL_HI    = 3;
  localparam int MODE_POST_SUB   = 4;

  localparam int PIPE_LAT = 4;

  typedef enum logic [1:0] {
    ZSEL_ZERO = 2'b00,
    ZSEL_C    = 2'b01,
    ZSEL_P    = 2'b10,
    ZSEL_RSVD = 2'b11
  } zsel_e;

  function automatic zsel_e mode_zsel(input logic [MODE_W-1:0] mode);
    return zsel_e'(mode[MODE_ZSEL_HI:MODE_ZSEL_LO]);
  endfunction

endpackage

// File: rtl/dsp_mac_pipe_acc_ctrl.sv
// Dot-product sample counter: decides when the accumulator restarts from
// zero and which stage-4 sample closes a dot product.
module dsp_acc_ctrl #(
  parameter int ACC_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic clr,
  input  logic valid,
  input  logic acc,
  output logic force_zero,
  output logic last
);

  localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(ACC_LEN - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          wrap_s;

  // Next count: any non-accumulate sample restarts the dot product
  always_comb begin
    wrap_s    = (cnt_r == CNT_MAX);
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = '0;
    end else if (valid && acc) begin
      if (wrap_s) begin
        cnt_nxt_s = '0;
      end else begin
        cnt_nxt_s = cnt_r + CW'(1);
      end
    end else if (valid) begin
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter register, frozen while the slice is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (ce) begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign force_zero = (cnt_r == '0);
  assign last       = valid && acc && wrap_s;

endmodule

// File: rtl/dsp_mac_pipe.sv
// Four-stage MAC slice: pre-adder, unsigned multiplier, post-adder with
// auto-restarting dot-product accumulator and optional saturation.
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int AW       = 18,
  parameter int BW       = 18,
  parameter int PW       = 48,
  parameter int ACC_LEN  = 8,
  parameter int SATURATE = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE,
  input  logic              CLR,
  input  logic              IN_VALID,
  input  logic [AW-1:0]     A,
  input  logic [BW-1:0]     B,
  input  logic [BW-1:0]     D,
  input  logic [PW-1:0]     C,
  input  logic [MODE_W-1:0] MODE,
  input  logic              CARRYIN,
  output logic [BW-1:0]     BCOUT,
  output logic [PW-1:0]     P,
  output logic              OUT_VALID,
  output logic              LAST,
  output logic              CARRYOUT,
  output logic              OVERFLOW
);

  localparam int MW = AW + BW;

  logic [PIPE_LAT-1:0] vld_r;

  logic [AW-1:0]     a1_r;
  logic [BW-1:0]     b1_r;
  logic [BW-1:0]     d1_r;
  logic [PW-1:0]     c1_r;
  logic [MODE_W-1:0] mode1_r;
  logic              cin1_r;

  logic [AW-1:0] a2_r;
  logic [BW-1:0] b2_r;
  logic [PW-1:0] c2_r;
  zsel_e         zsel2_r;
  logic          psub2_r;
  logic          cin2_r;

  logic [MW-1:0] m3_r;
  logic [PW-1:0] c3_r;
  zsel_e         zsel3_r;
  logic          psub3_r;
  logic          cin3_r;

  logic [PW-1:0] p_r;
  logic          co_r;
  logic          ovf_r;
  logic          last_r;

  logic [BW-1:0] b2_s;
  logic [MW-1:0] m_s;
  logic [PW:0]   x_s;
  logic [PW:0]   z_s;
  logic [PW:0]   r_s;
  logic          sat_s;
  logic [PW-1:0] p_nxt_s;
  logic          force_zero_s;
  logic          acc_last_s;

  // Pre-adder, modulo 2^BW
  always_comb begin
    b2_s = b1_r;
    if (mode1_r[MODE_PREADD_EN]) begin
      if (mode1_r[MODE_PREADD_SUB]) begin
        b2_s = d1_r - b1_r;
      end else begin
        b2_s = d1_r + b1_r;
      end
    end else begin
      b2_s = b1_r;
    end
  end

  assign m_s = MW'(a2_r) * MW'(b2_r);

  // Post-adder in PW+1 bits; a fresh dot product sees Z=0 instead of P
  always_comb begin
    x_s = (PW+1)'(m3_r);
    z_s = '0;
    case (zsel3_r)
      ZSEL_ZERO: z_s = '0;
      ZSEL_C:    z_s = {1'b0, c3_r};
      ZSEL_P:    z_s = force_zero_s ? '0 : {1'b0, p_r};
      ZSEL_RSVD: z_s = '0;
      default:   z_s = '0;
    endcase
    if (psub3_r) begin
      r_s = z_s - (x_s + (PW+1)'(cin3_r));
    end else begin
      r_s = z_s + x_s + (PW+1)'(cin3_r);
    end
    sat_s = (SATURATE != 0) && !psub3_r && r_s[PW];
    if (sat_s) begin
      p_nxt_s = '1;
    end else begin
      p_nxt_s = r_s[PW-1:0];
    end
  end

  dsp_acc_ctrl #(
    .ACC_LEN(ACC_LEN)
  ) u_acc_ctrl (
    .clk       (CLK),
    .rst_n     (RST_N),
    .ce        (CE),
    .clr       (CLR),
    .valid     (vld_r[PIPE_LAT-2]),
    .acc       (zsel3_r == ZSEL_P),
    .force_zero(force_zero_s),
    .last      (acc_last_s)
  );

  // Data stages 1-3 load on every enabled edge; validity is tracked separately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a1_r    <= '0;
      b1_r    <= '0;
      d1_r    <= '0;
      c1_r    <= '0;
      mode1_r <= '0;
      cin1_r  <= 1'b0;
      a2_r    <= '0;
      b2_r    <= '0;
      c2_r    <= '0;
      zsel2_r <= ZSEL_ZERO;
      psub2_r <= 1'b0;
      cin2_r  <= 1'b0;
      m3_r    <= '0;
      c3_r    <= '0;
      zsel3_r <= ZSEL_ZERO;
      psub3_r <= 1'b0;
      cin3_r  <= 1'b0;
    end else if (CE) begin
      a1_r    <= A;
      b1_r    <= B;
      d1_r    <= D;
      c1_r    <= C;
      mode1_r <= MODE;
      cin1_r  <= CARRYIN;
      a2_r    <= a1_r;
      b2_r    <= b2_s;
      c2_r    <= c1_r;
      zsel2_r <= mode_zsel(mode1_r);
      psub2_r <= mode1_r[MODE_POST_SUB];
      cin2_r  <= cin1_r;
      m3_r    <= m_s;
      c3_r    <= c2_r;
      zsel3_r <= zsel2_r;
      psub3_r <= psub2_r;
      cin3_r  <= cin2_r;
    end
  end

  // Valid pipe and result register; CLR flushes everything in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_r  <= '0;
      p_r    <= '0;
      co_r   <= 1'b0;
      ovf_r  <= 1'b0;
      last_r <= 1'b0;
    end else if (CE) begin
      if (CLR) begin
        vld_r  <= '0;
        p_r    <= '0;
        last_r <= 1'b0;
      end else begin
        vld_r  <= {vld_r[PIPE_LAT-2:0], IN_VALID};
        last_r <= acc_last_s;
        if (vld_r[PIPE_LAT-2]) begin
          p_r   <= p_nxt_s;
          co_r  <= r_s[PW];
          ovf_r <= sat_s;
        end
      end
    end
  end

  assign BCOUT     = b2_r;
  assign P         = p_r;
  assign OUT_VALID = vld_r[PIPE_LAT-1];
  assign LAST      = last_r;
  assign CARRYOUT  = co_r;
  assign OVERFLOW  = ovf_r;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: two instances (SATURATE 0 and 1) checked
// every cycle against a transaction-level model, plus hand-computed results.
module tb_dsp_mac_pipe;

  localparam int AW = 18;
  localparam int BW = 18;
  localparam int PW = 48;
  localparam int AL = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          ce       = 1'b1;
  logic          clr      = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] a        = '0;
  logic [BW-1:0] b        = '0;
  logic [BW-1:0] d        = '0;
  logic [PW-1:0] c        = '0;
  logic [4:0]    mode     = '0;
  logic          cin      = 1'b0;

  logic [BW-1:0] bcout     [2];
  logic [PW-1:0] p         [2];
  logic          out_valid [2];
  logic          last      [2];
  logic          co        [2];
  logic          ovf       [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .ACC_LEN(AL), .SATURATE(0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .CLR(clr), .IN_VALID(in_valid),
    .A(a), .B(b), .D(d), .C(c), .MODE(mode), .CARRYIN(cin),
    .BCOUT(bcout[0]), .P(p[0]), .OUT_VALID(out_valid[0]), .LAST(last[0]),
    .CARRYOUT(co[0]), .OVERFLOW(ovf[0])
  );

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .ACC_LEN(AL), .SATURATE(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .CLR(clr), .IN_VALID(in_valid),
    .A(a), .B(b), .D(d), .C(c), .MODE(mode), .CARRYIN(cin),
    .BCOUT(bcout[1]), .P(p[1]), .OUT_VALID(out_valid[1]), .LAST(last[1]),
    .CARRYOUT(co[1]), .OVERFLOW(ovf[1])
  );

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] d;
    logic [PW-1:0] c;
    logic [4:0]    mode;
    logic          cin;
  } smp_t;

  typedef struct packed {
    logic [PW-1:0] p;
    logic          co;
    logic          ovf;
  } res_t;

  typedef struct {
    logic [PW-1:0] p;
    logic          last;
    logic          co;
    logic          ovf;
  } rec_t;

  function automatic logic [BW-1:0] preadd(input smp_t s);
    if (!s.mode[0]) return s.b;
    else if (s.mode[1]) return s.d - s.b;
    else return s.d + s.b;
  endfunction

  function automatic res_t post(input smp_t s, input logic [PW-1:0] pprev,
                                input int cnt, input bit sat);
    logic [AW+BW-1:0] m;
    logic [PW:0]      x;
    logic [PW:0]      z;
    logic [PW:0]      r;
    res_t             o;
    m = (AW+BW)'(s.a) * (AW+BW)'(preadd(s));
    x = (PW+1)'(m);
    case (s.mode[3:2])
      2'b01:   z = {1'b0, s.c};
      2'b10:   z = (cnt == 0) ? '0 : {1'b0, pprev};
      default: z = '0;
    endcase
    if (s.mode[4]) r = z - (x + (PW+1)'(s.cin));
    else           r = z + x + (PW+1)'(s.cin);
    o.co = r[PW];
    if (sat && !s.mode[4] && r[PW]) begin
      o.p   = '1;
      o.ovf = 1'b1;
    end else begin
      o.p   = r[PW-1:0];
      o.ovf = 1'b0;
    end
    return o;
  endfunction

  function automatic smp_t kill(input smp_t s, input logic k);
    smp_t t;
    t   = s;
    t.v = s.v && !k;
    return t;
  endfunction

  function automatic logic [PW-1:0] acc_p(input int j);
    case (j)
      0:       return 48'd3;
      1:       return 48'd9;
      2:       return 48'd18;
      default: return 48'd30;
    endcase
  endfunction

  // Reference model: samples travel PIPE_LAT enabled edges, results computed on exit
  smp_t          pipe_m [3];
  logic [PW-1:0] m_p     [2];
  logic          m_co    [2];
  logic          m_ovf   [2];
  logic          m_valid [2];
  logic          m_last  [2];
  int            m_cnt   [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) pipe_m[k] <= '0;
      for (int i = 0; i < 2; i++) begin
        m_p[i] <= '0; m_co[i] <= 1'b0; m_ovf[i] <= 1'b0;
        m_valid[i] <= 1'b0; m_last[i] <= 1'b0; m_cnt[i] <= 0;
      end
    end else if (ce) begin
      pipe_m[0] <= {in_valid && !clr, a, b, d, c, mode, cin};
      pipe_m[1] <= kill(pipe_m[0], clr);
      pipe_m[2] <= kill(pipe_m[1], clr);
      for (int i = 0; i < 2; i++) begin
        if (clr) begin
          m_p[i] <= '0; m_valid[i] <= 1'b0; m_last[i] <= 1'b0; m_cnt[i] <= 0;
        end else if (pipe_m[2].v) begin
          m_p[i]     <= post(pipe_m[2], m_p[i], m_cnt[i], i == 1).p;
          m_co[i]    <= post(pipe_m[2], m_p[i], m_cnt[i], i == 1).co;
          m_ovf[i]   <= post(pipe_m[2], m_p[i], m_cnt[i], i == 1).ovf;
          m_valid[i] <= 1'b1;
          if (pipe_m[2].mode[3:2] == 2'b10) begin
            m_last[i] <= (m_cnt[i] == AL - 1);
            m_cnt[i]  <= (m_cnt[i] == AL - 1) ? 0 : m_cnt[i] + 1;
          end else begin
            m_last[i] <= 1'b0;
            m_cnt[i]  <= 0;
          end
        end else begin
          m_valid[i] <= 1'b0;
          m_last[i]  <= 1'b0;
        end
      end
    end
  end

  rec_t log0[$];
  rec_t log1[$];

  task automatic chk(input string nm, input int inst, input logic [63:0] got,
                     input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, inst, got, want);
    end
  endtask

  task automatic cyc();
    rec_t r;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("out_valid", i, 64'(out_valid[i]), 64'(m_valid[i]));
      chk("last", i, 64'(last[i]), 64'(m_last[i]));
      chk("p", i, 64'(p[i]), 64'(m_p[i]));
      chk("carryout", i, 64'(co[i]), 64'(m_co[i]));
      chk("overflow", i, 64'(ovf[i]), 64'(m_ovf[i]));
      chk("bcout", i, 64'(bcout[i]), 64'(preadd(pipe_m[1])));
      if (out_valid[i] && ce) begin
        r.p = p[i]; r.last = last[i]; r.co = co[i]; r.ovf = ovf[i];
        if (i == 0) log0.push_back(r);
        else        log1.push_back(r);
      end
    end
  endtask

  task automatic set(input logic v, input logic [AW-1:0] ia, input logic [BW-1:0] ib,
                     input logic [BW-1:0] id, input logic [PW-1:0] ic,
                     input logic [4:0] im, input logic ici);
    in_valid = v; a = ia; b = ib; d = id; c = ic; mode = im; cin = ici;
  endtask

  task automatic send(input logic [AW-1:0] ia, input logic [BW-1:0] ib,
                      input logic [BW-1:0] id, input logic [PW-1:0] ic,
                      input logic [4:0] im, input logic ici);
    set(1'b1, ia, ib, id, ic, im, ici);
    cyc();
  endtask

  task automatic acc(input logic [AW-1:0] ia);
    send(ia, 18'd3, 18'd0, 48'd0, 5'b01000, 1'b0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [PW-1:0] ep,
                         input logic el);
    if (idx < log0.size()) begin
      chk({nm, "_p"}, 0, 64'(log0[idx].p), 64'(ep));
      chk({nm, "_last"}, 0, 64'(log0[idx].last), 64'(el));
    end else begin
      chk({nm, "_missing"}, 0, 64'(log0.size()), 64'(idx + 1));
    end
    if (idx < log1.size()) begin
      chk({nm, "_p"}, 1, 64'(log1[idx].p), 64'(ep));
      chk({nm, "_last"}, 1, 64'(log1[idx].last), 64'(el));
    end else begin
      chk({nm, "_missing"}, 1, 64'(log1.size()), 64'(idx + 1));
    end
  endtask

  task automatic chk_count(input string nm, input int n);
    chk(nm, 0, 64'(log0.size()), 64'(n));
    chk(nm, 1, 64'(log1.size()), 64'(n));
  endtask

  task automatic clear_logs();
    log0.delete();
    log1.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_p", i, 64'(p[i]), 64'd0);
      chk("rst_valid", i, 64'(out_valid[i]), 64'd0);
      chk("rst_last", i, 64'(last[i]), 64'd0);
      chk("rst_co", i, 64'(co[i]), 64'd0);
      chk("rst_ovf", i, 64'(ovf[i]), 64'd0);
      chk("rst_bcout", i, 64'(bcout[i]), 64'd0);
    end
    rst_n = 1'b1;
    cyc();

    // Latency: valid appears on the fourth enabled edge, for one cycle only
    send(18'd2, 18'd10, 18'd10, 48'd20, 5'b00101, 1'b1);
    for (int i = 0; i < 2; i++) chk("t1_early", i, 64'(out_valid[i]), 64'd0);
    in_valid = 1'b0;
    repeat (2) begin
      cyc();
      for (int i = 0; i < 2; i++) chk("t1_early", i, 64'(out_valid[i]), 64'd0);
    end
    cyc();
    for (int i = 0; i < 2; i++) begin
      chk("t1_valid", i, 64'(out_valid[i]), 64'd1);
      chk("t1_p", i, 64'(p[i]), 64'd61);
      chk("t1_bcout", i, 64'(bcout[i]), 64'd20);
      chk("t1_co", i, 64'(co[i]), 64'd0);
    end
    cyc();
    for (int i = 0; i < 2; i++) chk("t1_after", i, 64'(out_valid[i]), 64'd0);
    idle(2);
    clear_logs();

    // Pre-subtract and post-subtract: 40 - (1*20 + 1)
    send(18'd1, 18'd10, 18'd30, 48'd40, 5'b10111, 1'b1);
    idle(6);
    chk_count("t2_n", 1);
    chk_log("t2", 0, 48'd19, 1'b0);
    if (log0.size() > 0) chk("t2_co", 0, 64'(log0[0].co), 64'd0);
    clear_logs();

    // Two back-to-back dot products of length 4
    for (int r = 0; r < 2; r++)
      for (int k = 1; k <= 4; k++) acc(AW'(k));
    idle(6);
    chk_count("t3_n", 8);
    for (int k = 0; k < 8; k++) chk_log("t3", k, acc_p(k % 4), (k % 4) == 3);
    clear_logs();

    // Same stream with a bubble and a 3-cycle stall
    acc(18'd1);
    idle(1);
    acc(18'd2);
    acc(18'd3);
    acc(18'd4);
    ce = 1'b0;
    set(1'b1, 18'd1, 18'd3, 18'd0, 48'd0, 5'b01000, 1'b0);
    repeat (3) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        chk("t4_frozen_p", i, 64'(p[i]), 64'd3);
        chk("t4_frozen_valid", i, 64'(out_valid[i]), 64'd0);
      end
    end
    ce = 1'b1;
    cyc();
    acc(18'd2);
    acc(18'd3);
    acc(18'd4);
    idle(8);
    chk_count("t4_n", 8);
    for (int k = 0; k < 8; k++) chk_log("t4", k, acc_p(k % 4), (k % 4) == 3);
    clear_logs();

    // Unsigned overflow: all-ones + 1
    send(18'd1, 18'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 5'b00100, 1'b0);
    idle(6);
    chk_count("t5_n", 1);
    if (log0.size() > 0) begin
      chk("t5_p", 0, 64'(log0[0].p), 64'd0);
      chk("t5_co", 0, 64'(log0[0].co), 64'd1);
      chk("t5_ovf", 0, 64'(log0[0].ovf), 64'd0);
    end
    if (log1.size() > 0) begin
      chk("t5_p", 1, 64'(log1[0].p), 64'hFFFF_FFFF_FFFF);
      chk("t5_co", 1, 64'(log1[0].co), 64'd1);
      chk("t5_ovf", 1, 64'(log1[0].ovf), 64'd1);
    end
    clear_logs();

    // CLR after two of four samples, with one more in flight
    acc(18'd1);
    acc(18'd2);
    idle(6);
    acc(18'd3);
    clr = 1'b1;
    set(1'b1, 18'd4, 18'd3, 18'd0, 48'd0, 5'b01000, 1'b0);
    cyc();
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t6_clr_p", i, 64'(p[i]), 64'd0);
      chk("t6_clr_valid", i, 64'(out_valid[i]), 64'd0);
    end
    idle(6);
    for (int k = 1; k <= 4; k++) acc(AW'(k));
    idle(6);
    chk_count("t6_n", 6);
    chk_log("t6", 0, 48'd3, 1'b0);
    chk_log("t6", 1, 48'd9, 1'b0);
    for (int k = 0; k < 4; k++) chk_log("t6", k + 2, acc_p(k), k == 3);
    clear_logs();

    // Reset mid-accumulation
    acc(18'd1);
    acc(18'd2);
    idle(6);
    rst_n = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 2; i++) begin
      chk("t7_rst_p", i, 64'(p[i]), 64'd0);
      chk("t7_rst_valid", i, 64'(out_valid[i]), 64'd0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) acc(AW'(k));
    idle(6);
    chk_count("t7_n", 6);
    chk_log("t7", 0, 48'd3, 1'b0);
    chk_log("t7", 1, 48'd9, 1'b0);
    for (int k = 0; k < 4; k++) chk_log("t7", k + 2, acc_p(k), k == 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
- Parametrised successor to the team's DSP48A1-style slice: pre-adder, unsigned multiplier, post-adder/accumulator.
- Fixed 4-stage pipeline with a valid-tracking sideband and a global stall (CE).
- New behaviour: a dot-product accumulator that auto-restarts every ACC_LEN valid samples and flags the last one, plus optional saturation.
- Sits in the datapath as the MAC engine behind filter/dot-product controllers.

Parameters:
- AW, 18, width of A.
- BW, 18, width of B and D; pre-adder result width.
- PW, 48, width of C and P.
- ACC_LEN, 8, samples per dot product; must be at least 1.
- SATURATE, 0, 1 = clamp P to all-ones on unsigned overflow.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CE  in  1  global clock enable; 0 freezes every register.
- CLR  in  1  synchronous abort; qualified by CE.
- IN_VALID  in  1  input sample valid.
- A  in  AW  multiplier operand.
- B  in  BW  pre-adder operand.
- D  in  BW  pre-adder operand.
- C  in  PW  post-adder operand.
- MODE  in  5  [0] preadd_en, [1] preadd_sub, [3:2] zsel, [4] post_sub.
- CARRYIN  in  1  post-adder carry/borrow in.
- BCOUT  out  BW  stage-2 pre-adder register.
- P  out  PW  result register.
- OUT_VALID  out  1  P updated this cycle.
- LAST  out  1  final sample of a dot product.
- CARRYOUT  out  1  bit PW of the post-adder result.
- OVERFLOW  out  1  saturation occurred.

Behaviour:
- Reset (RST_N=0, asynchronous): every register 0, including all four stages, the valid pipe and the counter; P, BCOUT, OUT_VALID, LAST, CARRYOUT and OVERFLOW read 0.
- CE=0: no register changes, including valid bits and the counter; outputs hold.
- Stage 1 (CE=1): register A, B, D, C, MODE, CARRYIN and IN_VALID.
- Stage 2 pre-adder, modulo 2^BW, carry dropped:
  - B2 = preadd_en ? (preadd_sub ? D-B : D+B) : B.
  - BCOUT = B2.
  - A and the controls are carried forward.
- Stage 3: M = A2*B2, full AW+BW bits, unsigned.
- Stage 4 post-adder, computed in PW+1 bits:
  - X = M zero-extended.
  - Z by zsel: 00 = 0, 01 = C, 10 = P (accumulate), 11 = 0.
  - post_sub=0: R = Z + X + CARRYIN.
  - post_sub=1: R = Z - (X + CARRYIN).
  - P <= R[PW-1:0]; CARRYOUT <= R[PW].
- Saturation:
  - SATURATE=1, post_sub=0 and R[PW]=1: P <= all ones, OVERFLOW <= 1.
  - Otherwise OVERFLOW <= 0.
- Latency: 4 rising edges with CE=1 from IN_VALID sampled to OUT_VALID=1.
  - OUT_VALID is the stage-4 valid bit.
  - Bubbles propagate; stage 4 invalid means P, CARRYOUT and OVERFLOW hold.
- Accumulate counter CNT, range 0..ACC_LEN-1, advances only on a valid stage-4 sample with zsel=10:
  - CNT=0: Z forced to 0 (fresh dot product).
  - LAST=1 with OUT_VALID when CNT=ACC_LEN-1; CNT wraps to 0.
  - ACC_LEN=1: every valid accumulate sample is LAST and starts fresh.
  - Valid stage-4 sample with zsel != 10: CNT <= 0, LAST=0.
  - LAST=0 whenever OUT_VALID=0.
- CLR=1 with CE=1:
  - Clears the valid pipe, CNT and P; in-flight samples are discarded.
  - Data registers may hold stale values.
  - IN_VALID in the same cycle is also discarded.
  - CLR has priority over every other update.
- Reset mid-accumulation: partial sum lost; the next accumulate sample starts fresh.
- MODE is pipelined with its data, so a mode change takes effect per sample with no cross-sample hazard.

Decomposition:
- Package dsp_mac_pkg:
  - MODE bit indices.
  - zsel encodings ZSEL_ZERO, ZSEL_C, ZSEL_P, ZSEL_RSVD.
  - Latency constant PIPE_LAT=4.
- Sub-module dsp_acc_ctrl owns CNT, the CNT=0 Z-forcing and LAST generation; it is parametrised by ACC_LEN.

Test Plan:
- Reset release, defaults: A=2, B=10, D=10, MODE=preadd_en, zsel=01, C=20, CARRYIN=1, IN_VALID pulsed once → exactly 4 cycles later OUT_VALID=1, BCOUT=20, P=61, CARRYOUT=0; OUT_VALID=0 on the next cycle.
- Pre-subtract and post-subtract: D=30, B=10, preadd_sub, A=1, zsel=01, C=40, post_sub, CARRYIN=1 → P=19, CARRYOUT=0.
- ACC_LEN=4, zsel=10, B=3, A=1,2,3,4 back-to-back then repeated → LAST on the 4th output with P=30; the 5th output is P=3 (fresh), not 33.
- Bubbles and stall:
  - Same stream with IN_VALID gaps and CE held low 3 cycles mid-stream → identical P/LAST sequence.
  - P frozen while CE=0.
- SATURATE=1, C=48'hFFFF_FFFF_FFFF, A=1, B=1, zsel=01 → P=48'hFFFF_FFFF_FFFF, OVERFLOW=1, CARRYOUT=1.
- SATURATE=0 with the same stimulus → P=0, CARRYOUT=1, OVERFLOW=0.
- CLR and RST_N after 2 of 4 accumulate samples → no OUT_VALID for the flushed samples, CNT=0; the next dot product equals the expected fresh sum.
